// File: rtl/team_06_disp_sched_pkg.sv
// team_06_disp_sched_pkg: shared state encoding and widths for the display update scheduler
package team_06_disp_sched_pkg;
    localparam int CNT_W    = 16;
    localparam int EFFECT_W = 3;
    typedef enum logic [2:0] {IDLE, SETTLE, ISSUE, WAIT, BACKOFF, GAP} state_t;
endpackage

// File: rtl/team_06_sched_timer.sv
// team_06_sched_timer: loadable down-counter that holds at zero and flags it
// Ports: clk, nrst (async active-low); load/load_val reload the count; en decrements; zero is high at count 0
module team_06_sched_timer
    import team_06_disp_sched_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) cnt <= '0;
        else       cnt <= load ? load_val : (en && cnt != '0) ? cnt - 1'b1 : cnt;
    assign zero = cnt == '0;
endmodule

// File: rtl/team_06_disp_update_sched.sv
// team_06_disp_update_sched: coalesces talkie/effect changes into rate-limited, retried display update transactions
// Ports: clk, nrst (async active-low); talkieState/current_effect are the values to mirror;
//        upd_req/upd_talkie/upd_effect with upd_ack/upd_done/upd_nack form the engine handshake;
//        busy is high outside IDLE, err is sticky retry exhaustion, retry_cnt counts reissues of the current update
module team_06_disp_update_sched
    import team_06_disp_sched_pkg::*;
#(
    parameter int SETTLE_CYC  = 1000,
    parameter int GAP_CYC     = 500,
    parameter int RETRY_CYC   = 2000,
    parameter int MAX_RETRY   = 3,
    parameter int REFRESH_CYC = 0
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                talkieState,
    input  logic [EFFECT_W-1:0] current_effect,
    output logic                upd_req,
    output logic                upd_talkie,
    output logic [EFFECT_W-1:0] upd_effect,
    input  logic                upd_ack,
    input  logic                upd_done,
    input  logic                upd_nack,
    output logic                busy,
    output logic                err,
    output logic [3:0]          retry_cnt
);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] RETRY_LD  = CNT_W'(RETRY_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC == 0 ? 0 : GAP_CYC - 1);
    localparam logic [CNT_W-1:0] REF_LD    = CNT_W'(REFRESH_CYC == 0 ? 0 : REFRESH_CYC - 1);
    localparam logic [3:0]       MAX_R     = 4'(MAX_RETRY);
    localparam logic             REF_EN    = REFRESH_CYC != 0;

    state_t            state, state_nx;
    logic [EFFECT_W:0] snap, prev_snap, sent_snap;
    logic              init_pend, refresh_pend, pending;
    logic              tmr_load, tmr_zero, latch, done_ok, err_nx;
    logic [CNT_W-1:0]  tmr_val;
    logic [3:0]        retry_nx;
    logic              ref_zero, ref_wrap, ref_load;

    assign snap     = {talkieState, current_effect};
    assign pending  = (snap != sent_snap) | init_pend | refresh_pend;
    assign upd_req  = state == ISSUE;
    assign busy     = state != IDLE;
    // a done always restarts the refresh period, so a wrap in that same cycle is dropped
    assign ref_wrap = REF_EN & ref_zero & ~upd_done;
    assign ref_load = upd_done | ref_wrap;

    team_06_sched_timer u_tmr (
        .clk(clk), .nrst(nrst), .load(tmr_load), .load_val(tmr_val), .en(1'b1), .zero(tmr_zero)
    );

    team_06_sched_timer u_ref (
        .clk(clk), .nrst(nrst), .load(ref_load), .load_val(REF_LD), .en(REF_EN), .zero(ref_zero)
    );

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        latch    = 1'b0;
        done_ok  = 1'b0;
        err_nx   = err;
        retry_nx = retry_cnt;
        case (state)
            IDLE: if (pending) begin
                state_nx = SETTLE;
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end
            SETTLE: if (snap != prev_snap) begin
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LD;
            end else if (tmr_zero) begin
                latch    = 1'b1;
                state_nx = ISSUE;
            end
            ISSUE: if (upd_ack) state_nx = WAIT;
            // nack takes priority over a coincident done
            WAIT: if (upd_nack) begin
                tmr_load = 1'b1;
                if (retry_cnt < MAX_R) begin
                    retry_nx = retry_cnt + 4'd1;
                    state_nx = BACKOFF;
                    tmr_val  = RETRY_LD;
                end else begin
                    err_nx   = 1'b1;
                    retry_nx = '0;
                    state_nx = GAP;
                    tmr_val  = GAP_LD;
                end
            end else if (upd_done) begin
                done_ok  = 1'b1;
                err_nx   = 1'b0;
                retry_nx = '0;
                state_nx = GAP;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end
            BACKOFF: if (tmr_zero) state_nx = ISSUE;
            GAP:     if (tmr_zero) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state        <= IDLE;
            prev_snap    <= '0;
            sent_snap    <= '0;
            init_pend    <= 1'b1;
            refresh_pend <= 1'b0;
            upd_talkie   <= 1'b0;
            upd_effect   <= '0;
            err          <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            state        <= state_nx;
            prev_snap    <= snap;
            err          <= err_nx;
            retry_cnt    <= retry_nx;
            refresh_pend <= done_ok ? 1'b0 : ref_wrap ? 1'b1 : refresh_pend;
            if (latch) {upd_talkie, upd_effect} <= snap;
            if (done_ok) begin
                sent_snap <= {upd_talkie, upd_effect};
                init_pend <= 1'b0;
            end
        end
endmodule

// File: tb/tb_team_06_disp_update_sched.sv
// tb_team_06_disp_update_sched: scoreboard bench with a behavioural I2C engine model per scheduler instance
module tb_team_06_disp_update_sched;
    localparam int S = 4, G = 3, R = 8, M = 2, RF = 50;

    logic       clk = 1'b0, nrst = 1'b0, talkie = 1'b0;
    logic [2:0] effect = 3'b000;
    logic       req0, req1, utalk0, utalk1, busy0, busy1, err0, err1;
    logic [2:0] ueff0, ueff1;
    logic [3:0] rcnt0, rcnt1;
    logic [1:0] req;
    logic [1:0] ack = 2'b00, done = 2'b00, nack = 2'b00;
    logic [2:0] tmr [2];
    int         cyc = 0, eng_nacks = 0, nack_req = 0, acks0 = 0, err_cyc = 0;
    int         checks = 0, failures = 0;
    logic [3:0] exp_q [$];

    assign req = {req1, req0};
    always #5 clk = ~clk;

    team_06_disp_update_sched #(
        .SETTLE_CYC(S), .GAP_CYC(G), .RETRY_CYC(R), .MAX_RETRY(M), .REFRESH_CYC(0)
    ) dut (
        .clk(clk), .nrst(nrst), .talkieState(talkie), .current_effect(effect),
        .upd_req(req0), .upd_talkie(utalk0), .upd_effect(ueff0),
        .upd_ack(ack[0]), .upd_done(done[0]), .upd_nack(nack[0]),
        .busy(busy0), .err(err0), .retry_cnt(rcnt0)
    );

    team_06_disp_update_sched #(
        .SETTLE_CYC(S), .GAP_CYC(G), .RETRY_CYC(R), .MAX_RETRY(M), .REFRESH_CYC(RF)
    ) dut_ref (
        .clk(clk), .nrst(nrst), .talkieState(talkie), .current_effect(effect),
        .upd_req(req1), .upd_talkie(utalk1), .upd_effect(ueff1),
        .upd_ack(ack[1]), .upd_done(done[1]), .upd_nack(nack[1]),
        .busy(busy1), .err(err1), .retry_cnt(rcnt1)
    );

    // engine: ack one cycle after req, done/nack five cycles after ack; only instance 0 ever nacks
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ack[i]  <= 1'b0;
            done[i] <= 1'b0;
            nack[i] <= 1'b0;
            if (!nrst) tmr[i] <= 3'd0;
            else if (req[i] && !ack[i]) begin
                ack[i] <= 1'b1;
                tmr[i] <= 3'd5;
            end else if (tmr[i] != 3'd0) begin
                tmr[i] <= tmr[i] - 3'd1;
                if (tmr[i] == 3'd1) begin
                    if (i == 0 && eng_nacks < nack_req) begin
                        nack[i]   <= 1'b1;
                        eng_nacks <= eng_nacks + 1;
                    end else done[i] <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ack[0]) acks0 <= acks0 + 1;
    end

    always @(negedge clk) if (err0) err_cyc <= err_cyc + 1;

    task automatic wait_rise(input int w);
        logic last = req[w];
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (req[w] && !last) return;
            last = req[w];
        end
        checks++; failures++;
        $display("FAIL rise_timeout dut=%0d got=no_rise exp=rise", w);
    endtask

    // sel: 0 done0, 1 done1, 2 dut idle, 3 req0 low, 4 err0 high
    task automatic wait_cond(input int sel);
        for (int n = 0; n < 400; n++) begin
            if (sel == 0 ? done[0] : sel == 1 ? done[1] : sel == 2 ? !busy0 : sel == 3 ? !req0 : err0) return;
            @(negedge clk);
        end
        checks++; failures++;
        $display("FAIL wait_timeout sel=%0d got=no_event exp=event", sel);
    endtask

    task automatic test_reset;
        int r, d;
        logic [3:0] e;
        nrst = 1'b0; talkie = 1'b0; effect = 3'b000;
        repeat (3) @(negedge clk);
        checks++;
        if ({req0, busy0, err0, rcnt0, utalk0, ueff0} !== 11'h000) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", {req0, busy0, err0, rcnt0, utalk0, ueff0}, 11'h000);
        end
        nrst = 1'b1; r = cyc; exp_q.push_back(4'b0000);
        wait_rise(0);
        checks++;
        if (cyc - r !== S + 1) begin failures++; $display("FAIL init_latency got=%0d exp=%0d", cyc - r, S + 1); end
        e = exp_q.pop_front();
        checks++;
        if ({utalk0, ueff0} !== e) begin failures++; $display("FAIL init_values got=%h exp=%h", {utalk0, ueff0}, e); end
        wait_cond(0); d = cyc;
        wait_cond(2);
        checks++;
        if (cyc - d !== G + 1) begin failures++; $display("FAIL busy_fall got=%0d exp=%0d", cyc - d, G + 1); end
    endtask

    task automatic test_coalesce;
        int k, a;
        logic [3:0] e;
        wait_cond(2);
        a = acks0;
        @(negedge clk) effect = 3'b010;
        @(negedge clk) effect = 3'b001;
        k = cyc; exp_q.push_back(4'b0001);
        wait_rise(0);
        checks++;
        if (cyc - k !== S + 1) begin failures++; $display("FAIL coalesce_latency got=%0d exp=%0d", cyc - k, S + 1); end
        e = exp_q.pop_front();
        checks++;
        if ({utalk0, ueff0} !== e) begin failures++; $display("FAIL coalesce_values got=%h exp=%h", {utalk0, ueff0}, e); end
        wait_cond(0); wait_cond(2);
        repeat (20) @(negedge clk);
        checks++;
        if (acks0 - a !== 1) begin failures++; $display("FAIL coalesce_count got=%0d exp=1", acks0 - a); end
    endtask

    task automatic test_retry;
        int a, ec, t;
        logic [3:0] e;
        wait_cond(2);
        a = acks0; ec = err_cyc;
        nack_req = eng_nacks + 2;
        @(negedge clk) effect = 3'b011;
        repeat (3) exp_q.push_back(4'b0011);
        for (int n = 0; n < 3; n++) begin
            wait_rise(0);
            e = exp_q.pop_front();
            checks++;
            if ({utalk0, ueff0} !== e) begin failures++; $display("FAIL retry_values got=%h exp=%h", {utalk0, ueff0}, e); end
            checks++;
            if (rcnt0 !== 4'(n)) begin failures++; $display("FAIL retry_cnt got=%0d exp=%0d", rcnt0, n); end
            if (n > 0) begin
                checks++;
                if (cyc - t !== 7 + R) begin failures++; $display("FAIL reissue_spacing got=%0d exp=%0d", cyc - t, 7 + R); end
            end
            t = cyc;
        end
        wait_cond(0);
        @(negedge clk);
        checks++;
        if (rcnt0 !== 4'd0) begin failures++; $display("FAIL retry_clear got=%0d exp=0", rcnt0); end
        checks++;
        if (acks0 - a !== 3) begin failures++; $display("FAIL retry_acks got=%0d exp=3", acks0 - a); end
        checks++;
        if (err_cyc - ec !== 0) begin failures++; $display("FAIL retry_err got=%0d exp=0", err_cyc - ec); end
    endtask

    task automatic test_exhaust;
        logic [3:0] e;
        wait_cond(2);
        nack_req = eng_nacks + 1000;
        @(negedge clk) effect = 3'b100;
        repeat (4) exp_q.push_back(4'b0100);
        for (int n = 0; n < 3; n++) begin
            wait_rise(0);
            e = exp_q.pop_front();
            checks++;
            if ({utalk0, ueff0} !== e) begin failures++; $display("FAIL exhaust_values got=%h exp=%h", {utalk0, ueff0}, e); end
            checks++;
            if (rcnt0 !== 4'(n)) begin failures++; $display("FAIL exhaust_cnt got=%0d exp=%0d", rcnt0, n); end
        end
        wait_cond(4);
        checks++;
        if ({err0, rcnt0} !== 5'b10000) begin failures++; $display("FAIL exhaust_err got=%b exp=%b", {err0, rcnt0}, 5'b10000); end
        nack_req = eng_nacks;
        wait_rise(0);
        e = exp_q.pop_front();
        checks++;
        if ({utalk0, ueff0, err0} !== {e, 1'b1}) begin
            failures++; $display("FAIL exhaust_reissue got=%h exp=%h", {utalk0, ueff0, err0}, {e, 1'b1});
        end
        wait_cond(0);
        @(negedge clk);
        checks++;
        if ({err0, rcnt0} !== 5'b00000) begin failures++; $display("FAIL err_clear got=%b exp=%b", {err0, rcnt0}, 5'b00000); end
    endtask

    task automatic test_wait_change;
        int d;
        logic [3:0] e;
        wait_cond(2);
        @(negedge clk) effect = 3'b101;
        exp_q.push_back(4'b0101);
        wait_rise(0);
        e = exp_q.pop_front();
        checks++;
        if ({utalk0, ueff0} !== e) begin failures++; $display("FAIL wait_first got=%h exp=%h", {utalk0, ueff0}, e); end
        wait_cond(3);
        talkie = 1'b1; exp_q.push_back(4'b1101);
        wait_cond(0); d = cyc;
        checks++;
        if ({utalk0, ueff0} !== 4'b0101) begin failures++; $display("FAIL wait_stable got=%h exp=%h", {utalk0, ueff0}, 4'b0101); end
        wait_rise(0);
        checks++;
        if (cyc - d !== G + S + 2) begin failures++; $display("FAIL wait_second_latency got=%0d exp=%0d", cyc - d, G + S + 2); end
        e = exp_q.pop_front();
        checks++;
        if ({utalk0, ueff0} !== e) begin failures++; $display("FAIL wait_second got=%h exp=%h", {utalk0, ueff0}, e); end
        wait_cond(0);
    endtask

    task automatic test_reset_mid;
        int r;
        logic [3:0] e;
        wait_cond(2);
        nack_req = eng_nacks + 1000;
        @(negedge clk) effect = 3'b110;
        repeat (4) exp_q.push_back(4'b1110);
        for (int n = 0; n < 3; n++) begin
            wait_rise(0);
            e = exp_q.pop_front();
            checks++;
            if ({utalk0, ueff0} !== e) begin failures++; $display("FAIL rmid_values got=%h exp=%h", {utalk0, ueff0}, e); end
        end
        wait_cond(4);
        wait_rise(0);
        e = exp_q.pop_front();
        wait_cond(3);
        checks++;
        if ({busy0, err0} !== 2'b11) begin failures++; $display("FAIL rmid_pre got=%b exp=11", {busy0, err0}); end
        #1 nrst = 1'b0;
        #1;
        checks++;
        if ({req0, busy0, err0} !== 3'b000) begin failures++; $display("FAIL rmid_async got=%b exp=000", {req0, busy0, err0}); end
        nack_req = eng_nacks;
        @(negedge clk) nrst = 1'b1;
        r = cyc; exp_q.push_back({talkie, effect});
        wait_rise(0);
        checks++;
        if (cyc - r !== S + 1) begin failures++; $display("FAIL rmid_latency got=%0d exp=%0d", cyc - r, S + 1); end
        e = exp_q.pop_front();
        checks++;
        if ({utalk0, ueff0} !== e) begin failures++; $display("FAIL rmid_init got=%h exp=%h", {utalk0, ueff0}, e); end
        wait_cond(0);
    endtask

    task automatic test_refresh;
        int d;
        for (int n = 0; n < 2; n++) begin
            wait_cond(1); d = cyc;
            wait_rise(1);
            checks++;
            if (cyc - d !== RF + S + 2) begin failures++; $display("FAIL refresh_period got=%0d exp=%0d", cyc - d, RF + S + 2); end
            checks++;
            if ({utalk1, ueff1} !== {talkie, effect}) begin
                failures++; $display("FAIL refresh_values got=%h exp=%h", {utalk1, ueff1}, {talkie, effect});
            end
        end
    endtask

    initial begin
        test_reset;
        test_coalesce;
        test_retry;
        test_exhaust;
        test_wait_change;
        test_reset_mid;
        test_refresh;
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
